// File: rtl/gb_apu_pkg.sv
// Shared constants for the APU channel controllers: register offsets, read masks
// and frame-sequencer step decode.
package gb_apu_pkg;

    localparam logic [2:0] NR10_OFS = 3'd0;
    localparam logic [2:0] NR11_OFS = 3'd1;
    localparam logic [2:0] NR12_OFS = 3'd2;
    localparam logic [2:0] NR13_OFS = 3'd3;
    localparam logic [2:0] NR14_OFS = 3'd4;

    // Bits that always read back as 1 (write-only or unimplemented).
    localparam logic [7:0] NR10_RMASK   = 8'h80;
    localparam logic [7:0] NR11_RMASK   = 8'h3F;
    localparam logic [7:0] NR12_RMASK   = 8'h00;
    localparam logic [7:0] NR13_RMASK   = 8'hFF;
    localparam logic [7:0] NR14_RMASK   = 8'hBF;
    localparam logic [7:0] UNUSED_RMASK = 8'hFF;

    // Bit n set = strobe fires when the sequencer enters step n.
    localparam logic [7:0] LEN_STEPS = 8'b0101_0101;
    localparam logic [7:0] SWP_STEPS = 8'b0100_0100;
    localparam logic [7:0] ENV_STEPS = 8'b1000_0000;

    // Parked here while powered off so the first wrap after power-on lands on step 0.
    localparam logic [2:0] STEP_POWER_OFF = 3'd7;

    typedef struct packed {
        logic len;
        logic swp;
        logic env;
    } fs_strobes_t;

    function automatic fs_strobes_t decode_step(input logic [2:0] step);
        fs_strobes_t s;
        s.len = LEN_STEPS[step];
        s.swp = SWP_STEPS[step];
        s.env = ENV_STEPS[step];
        return s;
    endfunction

endpackage

// File: rtl/gb_apu_frame_sequencer.sv
// 512 Hz frame sequencer: prescaler, 3-bit step counter and one-cycle strobes.
// GB_APU_FS_EXT_DIV_EN replaces the prescaler with an external fs_tick pulse.
module gb_apu_frame_sequencer
    import gb_apu_pkg::*;
#(
    parameter int DIV_COUNT = 8192
) (
    input  logic clk,
    input  logic reset,
    input  logic apu_on,
`ifdef GB_APU_FS_EXT_DIV_EN
    input  logic fs_tick,
`endif
    output logic clk_length_ctr,
    output logic clk_sweep,
    output logic clk_vol_env
);

    logic [2:0]  step;
    logic [2:0]  next_step;
    logic        advance;
    fs_strobes_t strobes;

    assign next_step = step + 3'd1;

`ifdef GB_APU_FS_EXT_DIV_EN
    assign advance = fs_tick;
`else
    localparam int PW = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;

    logic [PW-1:0] prescaler;

    assign advance = (prescaler == PW'(DIV_COUNT - 1));

    always_ff @(posedge clk) begin
        if (reset || !apu_on) begin
            prescaler <= '0;
        end else if (advance) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            step    <= '0;
            strobes <= '0;
        end else if (!apu_on) begin
            step    <= STEP_POWER_OFF;
            strobes <= '0;
        end else if (advance) begin
            step    <= next_step;
            strobes <= decode_step(next_step);
        end else begin
            strobes <= '0;
        end
    end

    assign clk_length_ctr = strobes.len;
    assign clk_sweep      = strobes.swp;
    assign clk_vol_env    = strobes.env;

endmodule

// File: rtl/gb_apu_pulse_ctrl.sv
// Pulse channel control front end: NR10-NR14 register file, trigger pulse, read mux,
// status flop and frame sequencer. GB_APU_FS_EXT_DIV_EN adds the fs_tick input.
module gb_apu_pulse_ctrl
    import gb_apu_pkg::*;
#(
    parameter int DIV_COUNT = 8192
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        apu_on,
    input  logic        reg_sel,
    input  logic [2:0]  reg_addr,
    input  logic        reg_we,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    input  logic        chan_enable,
    output logic        chan_status,
`ifdef GB_APU_FS_EXT_DIV_EN
    input  logic        fs_tick,
`endif
    output logic        clk_length_ctr,
    output logic        clk_sweep,
    output logic        clk_vol_env,
    output logic [2:0]  sweep_time,
    output logic        sweep_decreasing,
    output logic [2:0]  num_sweep_shifts,
    output logic [1:0]  wave_duty,
    output logic [5:0]  length,
    output logic [3:0]  initial_volume,
    output logic        envelope_increasing,
    output logic [2:0]  num_envelope_sweeps,
    output logic [10:0] frequency,
    output logic        single,
    output logic        start
);

    logic [6:0] nr10;
    logic [7:0] nr11;
    logic [7:0] nr12;
    logic [7:0] nr13;
    logic [2:0] nr14_freq_hi;
    logic       nr14_single;
    logic       write_en;

    assign write_en = reg_sel & reg_we & apu_on;

    always_ff @(posedge clk) begin
        if (reset || !apu_on) begin
            nr10         <= '0;
            nr11         <= '0;
            nr12         <= '0;
            nr13         <= '0;
            nr14_freq_hi <= '0;
            nr14_single  <= 1'b0;
            start        <= 1'b0;
        end else begin
            start <= 1'b0;
            if (write_en) begin
                case (reg_addr)
                    NR10_OFS: nr10 <= reg_wdata[6:0];
                    NR11_OFS: nr11 <= reg_wdata;
                    NR12_OFS: nr12 <= reg_wdata;
                    NR13_OFS: nr13 <= reg_wdata;
                    NR14_OFS: begin
                        nr14_single  <= reg_wdata[6];
                        nr14_freq_hi <= reg_wdata[2:0];
                        start        <= reg_wdata[7];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chan_status <= 1'b0;
        end else begin
            chan_status <= apu_on & chan_enable;
        end
    end

    // NOTE: combinational block assigns its output first so no path can infer a latch.
    always_comb begin
        reg_rdata = UNUSED_RMASK;
        case (reg_addr)
            NR10_OFS: reg_rdata = {1'b0, nr10} | NR10_RMASK;
            NR11_OFS: reg_rdata = {nr11[7:6], 6'b0} | NR11_RMASK;
            NR12_OFS: reg_rdata = nr12 | NR12_RMASK;
            NR13_OFS: reg_rdata = NR13_RMASK;
            NR14_OFS: reg_rdata = {1'b0, nr14_single, 6'b0} | NR14_RMASK;
            default:  reg_rdata = UNUSED_RMASK;
        endcase
    end

    assign sweep_time          = nr10[6:4];
    assign sweep_decreasing    = nr10[3];
    assign num_sweep_shifts    = nr10[2:0];
    assign wave_duty           = nr11[7:6];
    assign length              = nr11[5:0];
    assign initial_volume      = nr12[7:4];
    assign envelope_increasing = nr12[3];
    assign num_envelope_sweeps = nr12[2:0];
    assign frequency           = {nr14_freq_hi, nr13};
    assign single              = nr14_single;

    gb_apu_frame_sequencer #(
        .DIV_COUNT(DIV_COUNT)
    ) u_frame_sequencer (
        .clk           (clk),
        .reset         (reset),
        .apu_on        (apu_on),
`ifdef GB_APU_FS_EXT_DIV_EN
        .fs_tick       (fs_tick),
`endif
        .clk_length_ctr(clk_length_ctr),
        .clk_sweep     (clk_sweep),
        .clk_vol_env   (clk_vol_env)
    );

endmodule

// File: tb/tb_gb_apu_pulse_ctrl.sv
// Scoreboard bench for gb_apu_pulse_ctrl: driver feeds a behavioural model and queues
// the expected outputs; a monitor pops and compares one entry per clock edge.
module tb_gb_apu_pulse_ctrl;

    localparam int DIV = 4;

    logic        clk;
    logic        reset;
    logic        apu_on;
    logic        reg_sel;
    logic [2:0]  reg_addr;
    logic        reg_we;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic        chan_enable;
    logic        chan_status;
    logic        fs_tick;
    logic        clk_length_ctr;
    logic        clk_sweep;
    logic        clk_vol_env;
    logic [2:0]  sweep_time;
    logic        sweep_decreasing;
    logic [2:0]  num_sweep_shifts;
    logic [1:0]  wave_duty;
    logic [5:0]  length;
    logic [3:0]  initial_volume;
    logic        envelope_increasing;
    logic [2:0]  num_envelope_sweeps;
    logic [10:0] frequency;
    logic        single;
    logic        start;

    gb_apu_pulse_ctrl #(.DIV_COUNT(DIV)) dut (
        .clk                (clk),
        .reset              (reset),
        .apu_on             (apu_on),
        .reg_sel            (reg_sel),
        .reg_addr           (reg_addr),
        .reg_we             (reg_we),
        .reg_wdata          (reg_wdata),
        .reg_rdata          (reg_rdata),
        .chan_enable        (chan_enable),
        .chan_status        (chan_status),
`ifdef GB_APU_FS_EXT_DIV_EN
        .fs_tick            (fs_tick),
`endif
        .clk_length_ctr     (clk_length_ctr),
        .clk_sweep          (clk_sweep),
        .clk_vol_env        (clk_vol_env),
        .sweep_time         (sweep_time),
        .sweep_decreasing   (sweep_decreasing),
        .num_sweep_shifts   (num_sweep_shifts),
        .wave_duty          (wave_duty),
        .length             (length),
        .initial_volume     (initial_volume),
        .envelope_increasing(envelope_increasing),
        .num_envelope_sweeps(num_envelope_sweeps),
        .frequency          (frequency),
        .single             (single),
        .start              (start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        len;
        logic        swp;
        logic        env;
        logic        start;
        logic        status;
        logic [34:0] cfg;
        logic [7:0]  rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_len    = 0;
    int   n_swp    = 0;
    int   n_env    = 0;

    // Reference model: spec-level register bytes, step number and cycles since last step.
    logic [6:0] m_nr10;
    logic [7:0] m_nr11, m_nr12, m_nr13;
    logic [2:0] m_fhi;
    logic       m_single;
    int         m_step  = 0;
    int         m_ticks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return {1'b1, m_nr10};
            3'd1:    return {m_nr11[7:6], 6'h3F};
            3'd2:    return m_nr12;
            3'd3:    return 8'hFF;
            3'd4:    return {1'b1, m_single, 6'h3F};
            default: return 8'hFF;
        endcase
    endfunction

    task automatic model_clear();
        m_nr10 = '0; m_nr11 = '0; m_nr12 = '0; m_nr13 = '0; m_fhi = '0; m_single = 1'b0;
    endtask

    task automatic model_edge();
        exp_t e;
        bit   adv;
        e = '0;
        if (reset) begin
            model_clear();
            m_step  = 0;
            m_ticks = 0;
        end else if (!apu_on) begin
            model_clear();
            m_step  = 7;
            m_ticks = 0;
        end else begin
`ifdef GB_APU_FS_EXT_DIV_EN
            adv = fs_tick;
`else
            m_ticks++;
            adv = (m_ticks == DIV);
            if (adv) m_ticks = 0;
`endif
            if (adv) begin
                m_step = (m_step + 1) % 8;
                e.len  = (m_step % 2 == 0);
                e.swp  = (m_step == 2 || m_step == 6);
                e.env  = (m_step == 7);
            end
            if (reg_sel && reg_we) begin
                case (reg_addr)
                    3'd0: m_nr10 = reg_wdata[6:0];
                    3'd1: m_nr11 = reg_wdata;
                    3'd2: m_nr12 = reg_wdata;
                    3'd3: m_nr13 = reg_wdata;
                    3'd4: begin
                        m_single = reg_wdata[6];
                        m_fhi    = reg_wdata[2:0];
                        e.start  = reg_wdata[7];
                    end
                    default: ;
                endcase
            end
            e.status = chan_enable;
        end
        e.cfg   = {m_nr10[6:4], m_nr10[3], m_nr10[2:0], m_nr11[7:6], m_nr11[5:0],
                   m_nr12[7:4], m_nr12[3], m_nr12[2:0], m_fhi, m_nr13, m_single};
        e.rdata = model_read(reg_addr);
        exp_q.push_back(e);
    endtask

    // Drive one clock's worth of inputs at the falling edge and queue the prediction.
    task automatic cyc(input logic rst, input logic on, input logic sel, input logic we,
                       input logic [2:0] addr, input logic [7:0] wd, input logic en,
                       input logic tick);
        @(negedge clk);
        reset       = rst;
        apu_on      = on;
        reg_sel     = sel;
        reg_we      = we;
        reg_addr    = addr;
        reg_wdata   = wd;
        chan_enable = en;
        fs_tick     = tick;
        model_edge();
    endtask

    task automatic idle(input int n, input logic [2:0] addr);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, addr, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic wr(input logic [2:0] addr, input logic [7:0] wd);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, addr, wd, 1'b1, 1'b0);
    endtask

    // Returns after the edge following the last driven cycle, outputs settled.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic run_wraps(input int n);
`ifdef GB_APU_FS_EXT_DIV_EN
        for (int i = 0; i < n; i++) begin
            idle($urandom_range(0, 3), 3'd0);
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1);
        end
`else
        idle(n * DIV, 3'd0);
`endif
    endtask

    // Advance until the next edge would enter step target (with the prescaler about to wrap).
    task automatic seek_step(input int target, input string name);
        int guard = 0;
`ifdef GB_APU_FS_EXT_DIV_EN
        while (m_step != target - 1 && guard < 64) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1);
            guard++;
        end
`else
        while (!(m_step == target - 1 && m_ticks == DIV - 1) && guard < 64) begin
            idle(1, 3'd0);
            guard++;
        end
`endif
        if (guard >= 64) check({name, "_timeout"}, 64'd1, 64'd0);
    endtask

    // Monitor: one scoreboard entry per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("strobe_len", clk_length_ctr, e.len);
                check("strobe_swp", clk_sweep, e.swp);
                check("strobe_env", clk_vol_env, e.env);
                check("start", start, e.start);
                check("chan_status", chan_status, e.status);
                check("cfg_fields", {sweep_time, sweep_decreasing, num_sweep_shifts, wave_duty,
                                     length, initial_volume, envelope_increasing,
                                     num_envelope_sweeps, frequency, single}, e.cfg);
                check("reg_rdata", reg_rdata, e.rdata);
                n_len += int'(clk_length_ctr);
                n_swp += int'(clk_sweep);
                n_env += int'(clk_vol_env);
            end
        end
    end

    initial begin
        reset = 1'b1; apu_on = 1'b1; reg_sel = 1'b0; reg_we = 1'b0; reg_addr = '0;
        reg_wdata = '0; chan_enable = 1'b0; fs_tick = 1'b0;
        model_clear();

        // Reset, then park powered off so the sequencer restarts on step 0.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
        n_len = 0; n_swp = 0; n_env = 0;
        run_wraps(8);
        settle();
        check("len_count_8_wraps", n_len, 4);
        check("swp_count_8_wraps", n_swp, 2);
        check("env_count_8_wraps", n_env, 1);

        // Frequency and trigger.
        wr(3'd3, 8'hAB);
        wr(3'd4, 8'h87);
        settle();
        check("trig_start_high", start, 1'b1);
        check("trig_frequency", frequency, 11'h7AB);
        check("trig_single", single, 1'b0);
        idle(1, 3'd4);
        settle();
        check("trig_start_one_cycle", start, 1'b0);
        check("nr14_read", reg_rdata, 8'hBF);

        // Back-to-back triggers.
        wr(3'd4, 8'hC5);
        wr(3'd4, 8'h82);
        idle(1, 3'd4);

        // NR10-NR12 decode and read masks.
        wr(3'd0, 8'h7F);
        wr(3'd1, 8'h81);
        wr(3'd2, 8'hF7);
        idle(1, 3'd0);
        settle();
        check("nr10_fields", {sweep_time, sweep_decreasing, num_sweep_shifts}, 7'h7F);
        check("nr11_fields", {wave_duty, length}, 8'h81);
        check("nr12_fields", {initial_volume, envelope_increasing, num_envelope_sweeps}, 8'hF7);
        check("nr10_read", reg_rdata, 8'hFF);
        idle(1, 3'd1);
        settle();
        check("nr11_read", reg_rdata, 8'hBF);
        idle(1, 3'd2);
        settle();
        check("nr12_read", reg_rdata, 8'hF7);
        for (int a = 5; a < 8; a++) wr(3'(a), 8'h00);

        // Power-off for 3 cycles with a trigger attempt, then power on again.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 8'hFF, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 8'h80, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'h00, 1'b1, 1'b0);
        settle();
        check("off_fields_cleared", {frequency, initial_volume, wave_duty}, 17'h0);
        check("off_no_start", start, 1'b0);
        check("off_nr12_read", reg_rdata, 8'h00);
        run_wraps(1);
        settle();
        check("power_on_first_len", {clk_length_ctr, clk_sweep, clk_vol_env}, 3'b100);

        // Trigger write colliding with a step-2 wrap.
        seek_step(2, "collision");
`ifdef GB_APU_FS_EXT_DIV_EN
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 8'h80, 1'b1, 1'b1);
`else
        wr(3'd4, 8'h80);
`endif
        settle();
        check("collision", {start, clk_length_ctr, clk_sweep}, 3'b111);

        // Reset mid-sequence.
        wr(3'd2, 8'h5A);
        seek_step(5, "reset_seek");
`ifndef GB_APU_FS_EXT_DIV_EN
        idle(3, 3'd0);
`endif
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 8'h80, 1'b1, 1'b1);
        settle();
        check("reset_mid_outputs", {start, clk_length_ctr, clk_sweep, clk_vol_env,
                                    chan_status, frequency, initial_volume}, 20'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) != 0),
                1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)), 8'($urandom),
                1'($urandom), ($urandom_range(0, 3) == 0));
        end

        idle(2, 3'd0);
        settle();
        check("scoreboard_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
